uart_tx_buffered: RTL

Buffered 8N1 UART transmitter for the nonogram solver's return path: the upstream byte producer (the solution assembler) pushes bytes through a valid/ready handshake into an internal FIFO, and the block serializes them onto the `tx` line. It is the counterpart of the `uart_rx` receive path. Board bytes arrive over `uart_rx`; solution bytes leave through this block at the same baud rate on the same `clk_50mhz` domain. Buffering decouples the assembler from the slow serial line, so a full 11x11 solution can be emitted without per-byte stalls.

---
 rtl/uart_tx_buffered.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to build 8E1 frames with an even-parity bit.
module uart_tx_buffered #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_50mhz,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
  logic          par_bit;
`endif

  logic push;
  logic pop;
  logic have;
  logic bit_end;

  assign have     = fifo_count != '0;
  assign bit_end  = cnt == LAST;
  assign in_ready = fifo_count != FULL;
  assign push     = in_valid && in_ready;
  // Pop decision uses the pre-edge count, so a push into an
  // empty FIFO is popped one edge later.
  assign pop      = have &&
                    (state == IDLE || (state == STOP && bit_end));
  assign busy     = (state != IDLE) || have;
  assign tx_done  = (state == STOP) && bit_end;

  always_ff @(posedge clk_50mhz) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: ;
        START: begin
          if (bit_end) begin
            state <= DATA;
            idx   <= '0;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            idx   <= idx + 1'b1;
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par_bit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
      // A pop overrides the STOP->IDLE return: next start bit follows directly.
      if (pop) begin
        state   <= START;
        tx      <= 1'b0;
        shift   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
        par_bit <= ^mem[rd_ptr];
`endif
      end
    end
  end

endmodule
